// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32 core memory path:
// access size codes, arbiter state encoding and requester IDs.
package cpu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the IF/MEM requesters, the memory macro and the arbiter.
// slave = arbiter view, master = core + memory view.
interface mem_port_arbiter_if #(
    parameter int AW = 32
);

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          if_valid;
    logic          stall_if;

    logic          d_req;
    logic          d_we;
    logic [1:0]    d_size;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_valid;
    logic          d_misalign;
    logic          stall_mem;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        input  mem_rdata,
        output if_rdata, if_valid, stall_if,
        output d_rdata, d_valid, d_misalign, stall_mem,
        output mem_en, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_size, d_addr, d_wdata,
        output mem_rdata,
        input  if_rdata, if_valid, stall_if,
        input  d_rdata, d_valid, d_misalign, stall_mem,
        input  mem_en, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/mem_lane_align.sv
// Store lane steering: byte enables, replicated write data and
// misalignment detection for a data access.
module mem_lane_align
    import cpu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misalign
);

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        misalign  = 1'b0;
        unique case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = 4'b0011 << {addr[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                misalign  = addr[0];
            end
            default: begin
                misalign  = (addr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported I/D memory between the IF and MEM stages,
// sequencing each access over a fixed latency and producing stalls.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int LATENCY   = 1,
    parameter int MAX_D_RUN = 4,
    parameter int AW        = 32
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int RW = $clog2(MAX_D_RUN + 1);

    arb_state_t    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          own_q, own_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wd_q, wd_d;
    logic          we_q, we_d;
    logic [31:0]   if_rd_q, if_rd_d;
    logic [31:0]   d_rd_q, d_rd_d;
    logic          if_v_q, if_v_d;
    logic          d_v_q, d_v_d;
    logic          mis_q, mis_d;
    logic [RW-1:0] run_q, run_d;

    logic [3:0]    al_be;
    logic [31:0]   al_wd;
    logic          al_mis;
    logic          starve;
    logic          take_d;
    logic          take_f;

    mem_lane_align u_align (
        .size      (bus.d_size),
        .addr      (bus.d_addr[1:0]),
        .wdata     (bus.d_wdata),
        .be        (al_be),
        .wdata_rep (al_wd),
        .misalign  (al_mis)
    );

    // Requesters advance on their completion pulse, so a request seen
    // during RESP is already the next access and may be granted at once.
    assign starve = bus.if_req && (run_q == RW'(MAX_D_RUN));
    assign take_d = bus.d_req && !starve;
    assign take_f = bus.if_req && !take_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        own_d   = own_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        we_d    = we_q;
        if_rd_d = if_rd_q;
        d_rd_d  = d_rd_q;
        if_v_d  = 1'b0;
        d_v_d   = 1'b0;
        mis_d   = 1'b0;
        run_d   = bus.if_req ? run_q : '0;
        unique case (state_q)
            ARB_BUSY: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ARB_RESP;
                    if (own_q == REQ_D) begin
                        d_v_d  = 1'b1;
                        d_rd_d = we_q ? 32'h0 : bus.mem_rdata;
                    end else begin
                        if_v_d  = 1'b1;
                        if_rd_d = bus.mem_rdata;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                if (take_d && al_mis) begin
                    state_d = ARB_RESP;
                    mis_d   = 1'b1;
                end else if (take_d) begin
                    state_d = ARB_BUSY;
                    cnt_d   = 3'(LATENCY);
                    own_d   = REQ_D;
                    addr_d  = {bus.d_addr[AW-1:2], 2'b00};
                    be_d    = bus.d_we ? al_be : 4'b1111;
                    wd_d    = al_wd;
                    we_d    = bus.d_we;
                    if (bus.if_req && !starve) begin
                        run_d = run_q + RW'(1);
                    end
                end else if (take_f) begin
                    state_d = ARB_BUSY;
                    cnt_d   = 3'(LATENCY);
                    own_d   = REQ_IF;
                    addr_d  = {bus.if_addr[AW-1:2], 2'b00};
                    be_d    = 4'b1111;
                    wd_d    = 32'h0;
                    we_d    = 1'b0;
                    run_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            own_q   <= REQ_IF;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            if_rd_q <= '0;
            d_rd_q  <= '0;
            if_v_q  <= 1'b0;
            d_v_q   <= 1'b0;
            mis_q   <= 1'b0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            own_q   <= own_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            if_rd_q <= if_rd_d;
            d_rd_q  <= d_rd_d;
            if_v_q  <= if_v_d;
            d_v_q   <= d_v_d;
            mis_q   <= mis_d;
            run_q   <= run_d;
        end
    end

    assign bus.mem_en     = (state_q == ARB_BUSY);
    assign bus.mem_we     = bus.mem_en && we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_be     = be_q;
    assign bus.mem_wdata  = wd_q;
    assign bus.if_rdata   = if_rd_q;
    assign bus.if_valid   = if_v_q;
    assign bus.d_rdata    = d_rd_q;
    assign bus.d_valid    = d_v_q;
    assign bus.d_misalign = mis_q;
    assign bus.stall_if   = bus.if_req && !if_v_q;
    assign bus.stall_mem  = bus.d_req && !d_v_q && !mis_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed fetch/data traffic,
// memory-side and response-side monitors, reset mid-access.
module tb_mem_port_arbiter;
    import cpu_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } macc_t;

    typedef struct packed {
        logic        mis;
        logic [31:0] rdata;
    } dresp_t;

    logic clk = 1'b0;
    logic rst;
    logic rst3;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32)) b ();
    mem_port_arbiter_if #(.AW(32)) b3 ();

    mem_port_arbiter #(.LATENCY(1), .MAX_D_RUN(4), .AW(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    mem_port_arbiter #(.LATENCY(3), .MAX_D_RUN(4), .AW(32)) u_dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (b3)
    );

    logic [31:0] mem [0:255];
    assign b.mem_rdata  = mem[b.mem_addr[9:2]];
    assign b3.mem_rdata = b3.mem_addr ^ 32'h5A00_0000;

    always @(posedge clk) begin
        if (b.mem_en && b.mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (b.mem_be[i]) mem[b.mem_addr[9:2]][i*8 +: 8] <= b.mem_wdata[i*8 +: 8];
            end
        end
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_f[$];
    dresp_t      exp_d[$];
    macc_t       exp_m[$];
    int n_sif  = 0;
    int n_smem = 0;
    int n_v3   = 0;
    logic en_prev = 1'b0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got an unexpected event, expected none", nm);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (b.if_valid) begin
                if (exp_f.size() == 0) unexp("if_valid");
                else chk("if_rdata", b.if_rdata, exp_f.pop_front());
            end
            if (b.d_valid || b.d_misalign) begin
                if (exp_d.size() == 0) unexp("d_resp");
                else begin
                    dresp_t e;
                    e = exp_d.pop_front();
                    if (e.mis) chk("d_misalign", {b.d_valid, b.d_misalign}, 2'b01);
                    else chk("d_resp", {b.d_valid, b.d_misalign, b.d_rdata}, {2'b10, e.rdata});
                end
            end
            if (b.mem_en && !en_prev) begin
                if (exp_m.size() == 0) unexp("mem_access");
                else chk("mem_access",
                         {b.mem_addr, b.mem_be, b.mem_we, b.mem_we ? b.mem_wdata : 32'h0},
                         exp_m.pop_front());
            end
        end
        en_prev <= b.mem_en;
        if (b.stall_if)  n_sif  <= n_sif + 1;
        if (b.stall_mem) n_smem <= n_smem + 1;
        if (b3.if_valid || b3.d_valid) n_v3 <= n_v3 + 1;
    end

    task automatic pm(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
        exp_m.push_back({a, be, we, wd});
    endtask

    task automatic pd(input logic mis, input logic [31:0] rd);
        exp_d.push_back({mis, rd});
    endtask

    task automatic wait_done(input bit is_d, input string nm);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            done = is_d ? (b.d_valid || b.d_misalign) : b.if_valid;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no completion after %0d cycles, expected one", nm, n);
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        b.if_req  = 1'b1;
        b.if_addr = a;
        wait_done(1'b0, "fetch");
    endtask

    task automatic dacc(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        b.d_req   = 1'b1;
        b.d_we    = we;
        b.d_size  = sz;
        b.d_addr  = a;
        b.d_wdata = wd;
        wait_done(1'b1, "data");
    endtask

    task automatic gap();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int bs_if;
        int bs_mem;
        int n;
        rst  = 1'b0;
        rst3 = 1'b0;
        b.if_req = 1'b0;  b.if_addr = '0;
        b.d_req  = 1'b0;  b.d_we = 1'b0;  b.d_size = 2'b00;
        b.d_addr = '0;    b.d_wdata = '0;
        b3.if_req = 1'b0; b3.if_addr = '0;
        b3.d_req  = 1'b0; b3.d_we = 1'b0; b3.d_size = 2'b00;
        b3.d_addr = '0;   b3.d_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'h0050_0093;
        mem[8'h05] = 32'h00A0_0113;
        mem[8'h08] = 32'h0010_0013;
        mem[8'h09] = 32'h0020_0013;
        mem[8'h40] = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem", {b.mem_en, b.mem_we, b.mem_be, b.mem_addr}, 38'h0);
        chk("reset_wdata", b.mem_wdata, 32'h0);
        chk("reset_pulses", {b.if_valid, b.d_valid, b.d_misalign}, 3'b000);
        chk("reset_rdata", {b.if_rdata, b.d_rdata}, 64'h0);
        b.if_req = 1'b1;
        #1;
        chk("reset_stall_if", b.stall_if, 1'b1);
        b.if_req = 1'b0;
        #1;
        chk("reset_stall_if_low", b.stall_if, 1'b0);
        rst  = 1'b1;
        rst3 = 1'b1;
        gap();

        // fetch only
        pm(32'h10, 4'hF, 1'b0, 32'h0);
        exp_f.push_back(32'h0050_0093);
        bs_if = n_sif;
        fetch(32'h10);
        b.if_req = 1'b0;
        chk("fetch_stall_cycles", n_sif - bs_if, 2);
        gap();

        // simultaneous fetch and load: data first
        pm(32'h100, 4'hF, 1'b0, 32'h0);
        pm(32'h14, 4'hF, 1'b0, 32'h0);
        pd(1'b0, 32'hDEAD_BEEF);
        exp_f.push_back(32'h00A0_0113);
        bs_if = n_sif;
        bs_mem = n_smem;
        fork
            begin dacc(1'b0, SZ_WORD, 32'h100, 32'h0); b.d_req = 1'b0; end
            begin fetch(32'h14); b.if_req = 1'b0; end
        join
        chk("sim_stall_if", n_sif - bs_if, 4);
        chk("sim_stall_mem", n_smem - bs_mem, 2);
        gap();

        // byte store, half store, then load merging both
        pm(32'h100, 4'b1000, 1'b1, 32'hABAB_ABAB);
        pd(1'b0, 32'h0);
        pm(32'h100, 4'b1100, 1'b1, 32'h1234_1234);
        pd(1'b0, 32'h0);
        pm(32'h100, 4'hF, 1'b0, 32'h0);
        pd(1'b0, 32'h1234_BEEF);
        dacc(1'b1, SZ_BYTE, 32'h103, 32'h0000_00AB);
        dacc(1'b1, SZ_HALF, 32'h102, 32'h0000_1234);
        dacc(1'b0, SZ_WORD, 32'h100, 32'h0);
        b.d_req = 1'b0;
        gap();

        // misaligned word and half: pulse, no memory access
        pd(1'b1, 32'h0);
        pd(1'b1, 32'h0);
        dacc(1'b0, SZ_WORD, 32'h102, 32'h0);
        dacc(1'b1, SZ_HALF, 32'h101, 32'h5555);
        b.d_req = 1'b0;
        gap();

        // data run capped at 4 while a fetch waits
        for (int i = 0; i < 4; i++) pm(32'h200 + 4*i, 4'hF, 1'b1, 32'hC0DE_0000 + i);
        pm(32'h20, 4'hF, 1'b0, 32'h0);
        pm(32'h210, 4'hF, 1'b1, 32'hC0DE_0004);
        pm(32'h214, 4'hF, 1'b1, 32'hC0DE_0005);
        pm(32'h24, 4'hF, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) pd(1'b0, 32'h0);
        exp_f.push_back(32'h0010_0013);
        exp_f.push_back(32'h0020_0013);
        fork
            begin
                for (int i = 0; i < 6; i++) dacc(1'b1, SZ_WORD, 32'h200 + 4*i, 32'hC0DE_0000 + i);
                b.d_req = 1'b0;
            end
            begin
                fetch(32'h20);
                fetch(32'h24);
                b.if_req = 1'b0;
            end
        join
        gap();

        // reset mid-access on the LATENCY=3 instance
        b3.if_req  = 1'b1;
        b3.if_addr = 32'h40;
        @(posedge clk);
        #1;
        chk("rst_mid_en_busy", b3.mem_en, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_en_before", b3.mem_en, 1'b1);
        rst3 = 1'b0;
        #1;
        chk("rst_mid_en_dropped", b3.mem_en, 1'b0);
        b3.if_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst3 = 1'b1;
        gap();
        chk("rst_mid_no_valid", n_v3, 0);
        b3.if_req  = 1'b1;
        b3.if_addr = 32'h44;
        n = 0;
        while (!b3.if_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        b3.if_req = 1'b0;
        chk("rst_after_latency", n, 4);
        chk("rst_after_rdata", b3.if_rdata, 32'h5A00_0044);
        @(negedge clk);
        #1;
        chk("rst_after_valid_count", n_v3, 1);

        repeat (4) @(posedge clk);
        #1;
        chk("queues_drained", exp_f.size() + exp_d.size() + exp_m.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
